// File: rtl/apb_mem_pkg.sv
// Shared types, constants and helpers for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int WAIT_CNT_WD  = 4;

  localparam int DEF_ADDR_WD  = 32;
  localparam int DEF_DATA_WD  = 32;
  localparam int DEF_PROT_WD  = 3;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_WAIT_CYC = 0;
  localparam int DEF_PROT_CHK = 1;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WD storage: one byte-wide array per lane, synchronous
// byte-enabled write and asynchronous read at the same index.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DATA_WD = DEF_DATA_WD
) (
  input  logic                      b_pclk,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WD-1:0]        wdata,
  input  logic [DATA_WD/8-1:0]      wstrb,
  output logic [DATA_WD-1:0]        rdata
);

  // Splitting by lane keeps every array single-writer.
  for (genvar gi = 0; gi < DATA_WD / 8; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge b_pclk) begin
      if (wr_en && wstrb[gi]) begin
        lane_mem[idx] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[idx];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave with byte strobes, programmable wait states and
// PSLVERR on misaligned, out-of-range or rejected non-secure writes.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WD  = DEF_ADDR_WD,
  parameter int DATA_WD  = DEF_DATA_WD,
  parameter int STRB_WD  = DATA_WD / 8,
  parameter int PROT_WD  = DEF_PROT_WD,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WAIT_CYC = DEF_WAIT_CYC,
  parameter int PROT_CHK = DEF_PROT_CHK
) (
  input  logic               b_pclk,
  input  logic               b_prst_n,
  input  logic               b_psel,
  input  logic               b_penable,
  input  logic               b_pwrite,
  input  logic [ADDR_WD-1:0] b_paddr,
  input  logic [DATA_WD-1:0] b_pwdata,
  input  logic [PROT_WD-1:0] b_pprot,
  input  logic [STRB_WD-1:0] b_pstrb,
  output logic [DATA_WD-1:0] b_prdata,
  output logic               b_pready,
  output logic               b_pslverr
);

  localparam int IW = clog2(DEPTH);

  apb_state_e             state_reg;
  logic [WAIT_CNT_WD-1:0] cnt_reg;
  logic                   err_reg;
  logic                   err_next;
  logic                   err_addr;
  logic                   err_prot;
  logic [IW-1:0]          idx;
  logic                   mem_we;
  logic [DATA_WD-1:0]     mem_rdata;
  logic                   unused_prot;

  assign idx         = b_paddr[IW+1:2];
  assign err_addr    = (b_paddr[1:0] != 2'b00) || ((b_paddr >> (IW + 2)) != '0);
  assign err_prot    = (PROT_CHK != 0) && b_pwrite && b_pprot[1];
  assign err_next    = err_addr || err_prot;
  assign unused_prot = ^b_pprot;

  assign b_pready  = (state_reg == ACCESS) && (cnt_reg == '0) && b_psel && b_penable;
  assign b_pslverr = b_pready && err_reg;
  assign b_prdata  = (b_pready && !b_pwrite && !err_reg) ? mem_rdata : '0;
  assign mem_we    = b_pready && b_pwrite && !err_reg;

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (b_psel && !b_penable) begin
            state_reg <= ACCESS;
            cnt_reg   <= WAIT_CNT_WD'(WAIT_CYC);
            err_reg   <= err_next;
          end
        end
        ACCESS: begin
          // A dropped select abandons the transfer without a response.
          if (!b_psel || b_pready) begin
            state_reg <= IDLE;
          end else if (b_penable && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  apb_mem_array #(
    .DEPTH   (DEPTH),
    .DATA_WD (DATA_WD)
  ) u_array (
    .b_pclk (b_pclk),
    .wr_en  (mem_we),
    .idx    (idx),
    .wdata  (b_pwdata),
    .wstrb  (b_pstrb),
    .rdata  (mem_rdata)
  );

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave. It is the next generation of the team's zero-wait APB RAM slave and sits on the b_pclk side of the APB asynchronous bridge. Compared with the zero-wait slave it adds:
- configurable depth;
- byte-strobe writes;
- programmable wait states;
- PSLVERR on illegal accesses;
- an explicit setup/access FSM.

Parameters:
ADDR_WD, 32, APB address width
DATA_WD, 32, APB data width; multiple of 8
STRB_WD, DATA_WD/8, byte-strobe width
PROT_WD, 3, b_pprot width
DEPTH, 256, number of DATA_WD words; power of two, ≥2
WAIT_CYC, 0, wait states inserted in every access phase (0..15)
PROT_CHK, 1, 1 = writes with b_pprot[1]=1 (non-secure) are rejected with error

Ports:
b_pclk  in  1  APB clock
b_prst_n  in  1  asynchronous active-low reset
b_psel  in  1  slave select
b_penable  in  1  access phase
b_pwrite  in  1  1 = write, 0 = read
b_paddr  in  ADDR_WD  byte address
b_pwdata  in  DATA_WD  write data
b_pprot  in  PROT_WD  protection attributes
b_pstrb  in  STRB_WD  write byte lanes
b_prdata  out  DATA_WD  read data
b_pready  out  1  transfer complete
b_pslverr  out  1  transfer error; valid only with b_pready

Behaviour:
Reset and clocking:
- One clock (b_pclk). Reset b_prst_n is asynchronous, active-low.
- Reset values: FSM=IDLE, wait counter=0, b_pready=0, b_pslverr=0, b_prdata=0.
- Memory contents are not reset; they are undefined after power-up.

Address decode:
- Index width IW = clog2(DEPTH). Index = b_paddr[IW+1:2].
- err_addr = (b_paddr[1:0]!=0) | (b_paddr[ADDR_WD-1:IW+2]!=0). This includes out-of-range addresses.
- err_prot = PROT_CHK & b_pwrite & b_pprot[1].
- err = err_addr | err_prot. It is computed and registered in the setup cycle.

FSM:
- IDLE:
  - On b_psel & !b_penable (setup): latch err, load cnt=WAIT_CYC, go to ACCESS.
  - Any other input: stay in IDLE.
- ACCESS:
  - b_pready = (cnt==0) & b_psel & b_penable (combinational from registered state).
  - While cnt≠0 and b_penable=1: cnt decrements by 1 per cycle.
  - On completion (b_pready=1): go to IDLE.
    - Write, no error: mem[index] byte lane i ← b_pwdata[8i+7:8i] where b_pstrb[i]=1. Lanes with b_pstrb[i]=0 are unchanged.
    - Read, no error: b_prdata = mem[index] in the same cycle.
    - Error: no memory update; b_prdata=0; b_pslverr=1.
  - If b_psel falls in ACCESS (abort): go to IDLE, no write, no response.

Latency and output rules:
- Access phase lasts WAIT_CYC+1 cycles. With WAIT_CYC=0 the transfer completes on the first access cycle.
- b_prdata is 0 whenever b_pready=0 or b_pwrite=1.
- b_pslverr is 0 whenever b_pready=0.
- Back-to-back transfers always pass through a setup cycle. A read immediately after a write to the same index returns the new data.
- Address and control inputs that change during ACCESS are sampled at completion for index, data and strobes. Error status is the value latched at setup.
- Reset asserted mid-transfer: immediate return to IDLE, outputs 0, no partial write.
- Read with b_pstrb≠0: b_pstrb is ignored; the read completes normally.

Decomposition:
Package apb_mem_pkg:
- FSM state enum (IDLE, ACCESS).
- clog2 function.
- WAIT_CNT_WD=4 constant.
- Default parameter constants.

Sub-module apb_mem_array (DEPTH × DATA_WD, byte-enable synchronous write, asynchronous read):
- Instantiated once.
- The FSM, counter and error logic stay in the top-level module.

Test Plan:
1. WAIT_CYC=0: write 0xDEADBEEF to 0x10 with pstrb=4'hF, then read 0x10 -> b_pready high on the first access cycle both times; b_prdata=0xDEADBEEF; b_pslverr=0.
2. Preload 0x11223344 at 0x20; write 0xAABBCCDD with pstrb=4'b0101; read 0x20 -> 0x11BB33DD.
3. WAIT_CYC=3: read 0x04 -> b_pready low for 3 access cycles, high on the 4th; b_prdata is 0 until then.
4. DEPTH=256: write to 0x400, then write to 0x02 -> each completes with b_pslverr=1 and memory unchanged; a subsequent read of 0x00 returns the prior value.
5. PROT_CHK=1: write with pprot=3'b010 -> b_pslverr=1, no update. Read with the same pprot -> b_pslverr=0, data returned.
6. WAIT_CYC=2: drop b_psel in the 2nd access cycle of a write -> FSM returns to IDLE, memory unchanged. Separately, assert b_prst_n=0 mid-access -> b_pready, b_pslverr and b_prdata are 0 immediately, and the next transfer completes normally.
